// File: rtl/ddr_clk_seq_pkg.sv
// Shared state encoding and default timing for the DDR cluster clock/reset sequencer.
package ddr_clk_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_CKEN  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_WARM  = 3'd4,
      ST_DBG   = 3'd5,
      ST_DRAIN = 3'd6
   } state_e;

   localparam int unsigned CKEN_SETUP_DEF = 4;
   localparam int unsigned RST_HOLD_DEF   = 16;
   localparam int unsigned DBG_HOLD_DEF   = 8;
   localparam int unsigned CNT_W_DEF      = 8;

endpackage

// File: rtl/ddr_clk_seq_cnt.sv
// Loadable down-counter that holds at zero; zero_c flags the last cycle of a timed state.
module ddr_clk_seq_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ddr_clk_rst_seq.sv
// DDR cluster clock/reset sequencer: starts the clock before releasing reset,
// issues fixed-length warm/debug pulses and asserts reset before gating the clock.
module ddr_clk_rst_seq
   import ddr_clk_seq_pkg::*;
#(
   parameter int unsigned CKEN_SETUP = CKEN_SETUP_DEF,
   parameter int unsigned RST_HOLD   = RST_HOLD_DEF,
   parameter int unsigned DBG_HOLD   = DBG_HOLD_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic       rclk,
   input  logic       rst,
   input  logic       start,
   input  logic       warm_req,
   input  logic       dbg_req,
   input  logic       stop_req,
   output logic       cluster_cken,
   output logic       grst_l,
   output logic       gdbginit_l,
   output logic       busy,
   output logic       ack,
   output logic [2:0] state
);

   state_e           state_q;
   state_e           state_d;
   logic             cnt_zero_c;
   logic             load_c;
   logic [CNT_W-1:0] load_val_c;

   logic cken_q, grst_l_q, gdbginit_l_q, busy_q, ack_q;
   logic cken_d, grst_l_d, gdbginit_l_d, busy_d, ack_d;

   always_ff @(posedge rclk) begin
      if (rst) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: stop beats warm beats debug; a timed state leaves when the count hits zero.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF: begin
            if (start) state_d = ST_CKEN;
         end
         ST_CKEN: begin
            if (stop_req)        state_d = ST_DRAIN;
            else if (cnt_zero_c) state_d = ST_HOLD;
         end
         ST_HOLD, ST_WARM: begin
            if (stop_req)        state_d = ST_DRAIN;
            else if (cnt_zero_c) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (stop_req)      state_d = ST_DRAIN;
            else if (warm_req) state_d = ST_WARM;
            else if (dbg_req)  state_d = ST_DBG;
         end
         ST_DBG: begin
            if (stop_req)        state_d = ST_DRAIN;
            else if (warm_req)   state_d = ST_WARM;
            else if (cnt_zero_c) state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (cnt_zero_c) state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase
   end

   // Counter reloads only on entry to a timed state, so absorbed requests never extend it.
   always_comb begin
      load_c     = 1'b0;
      load_val_c = '0;
      if (state_d != state_q) begin
         case (state_d)
            ST_CKEN, ST_DRAIN: begin
               load_c     = 1'b1;
               load_val_c = CNT_W'(CKEN_SETUP - 1);
            end
            ST_HOLD, ST_WARM: begin
               load_c     = 1'b1;
               load_val_c = CNT_W'(RST_HOLD - 1);
            end
            ST_DBG: begin
               load_c     = 1'b1;
               load_val_c = CNT_W'(DBG_HOLD - 1);
            end
            default: begin
               load_c     = 1'b0;
               load_val_c = '0;
            end
         endcase
      end
   end

   ddr_clk_seq_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (rclk),
      .rst      (rst),
      .load     (load_c),
      .load_val (load_val_c),
      .zero_c   (cnt_zero_c)
   );

   // Outputs decoded from the next state so the registered copy lines up with state_q.
   always_comb begin
      cken_d       = (state_d != ST_OFF);
      grst_l_d     = (state_d == ST_RUN) || (state_d == ST_DBG);
      gdbginit_l_d = (state_d == ST_RUN);
      busy_d       = (state_d != ST_OFF) && (state_d != ST_RUN);
      ack_d        = (state_d == ST_RUN) && (state_q != ST_RUN);
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         cken_q       <= 1'b0;
         grst_l_q     <= 1'b0;
         gdbginit_l_q <= 1'b0;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         cken_q       <= cken_d;
         grst_l_q     <= grst_l_d;
         gdbginit_l_q <= gdbginit_l_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
      end
   end

   assign cluster_cken = cken_q;
   assign grst_l       = grst_l_q;
   assign gdbginit_l   = gdbginit_l_q;
   assign busy         = busy_q;
   assign ack          = ack_q;
   assign state        = state_q;

endmodule
